// File: rtl/pulse_capture_ctrl.sv
// Pulse capture controller: writes a pre/post-trigger window of ADC samples
// into a circular sample buffer, keyed on the rising edge of the trigger level.
module pulse_capture_ctrl #(
    parameter int AW = 10,
    parameter int DW = 14
) (
    input  logic          adc_clk,
    input  logic          adc_rstn,
    input  logic [DW-1:0] adc_dat_a,
    input  logic          trig_in,
    input  logic          arm,
    input  logic          abort,
    input  logic [AW-1:0] pre_len,
    input  logic [AW-1:0] post_len,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_dat,
    output logic [AW-1:0] trig_addr,
    output logic          busy,
    output logic          done,
    output logic [15:0]   evt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          trig_d;
    logic          trig_edge;
    logic          writing;
    logic          idle_arm;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] seg_cnt;
    logic [AW-1:0] seg_cnt_inc;
    logic [AW-1:0] pre_q;
    logic [AW-1:0] post_q;
    logic [AW-1:0] pre_lim;

    // A level already high when sampled by trig_d never produces an edge.
    assign trig_edge   = trig_in & ~trig_d;
    assign writing     = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign idle_arm    = ((state == S_IDLE) || (state == S_DONE)) && arm;
    assign seg_cnt_inc = seg_cnt + AW'(1);
    // A zero pre-trigger length still takes one sample before trigger search.
    assign pre_lim     = (pre_q == '0) ? AW'(1) : pre_q;

    // Next-state decode; abort outranks arm and trigger edge.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (arm) state_nxt = S_PRE;
                S_PRE:          if (seg_cnt_inc == pre_lim) state_nxt = S_WAIT;
                S_WAIT:         if (trig_edge) state_nxt = (post_q == '0) ? S_DONE : S_POST;
                S_POST:         if (seg_cnt_inc == post_q) state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // State register with busy/done decoded from the next state so they are registered.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_PRE) || (state_nxt == S_WAIT) || (state_nxt == S_POST);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Buffer write path, segment counter, trigger address and event counter.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            trig_d    <= 1'b0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_dat   <= '0;
            wr_ptr    <= '0;
            seg_cnt   <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            trig_addr <= '0;
            evt_cnt   <= '0;
        end else begin
            trig_d <= trig_in;
            if (abort) begin
                buf_we <= 1'b0;
            end else if (writing) begin
                buf_we   <= 1'b1;
                buf_addr <= wr_ptr;
                buf_dat  <= adc_dat_a;
                wr_ptr   <= wr_ptr + AW'(1);
                // Segment counter restarts whenever the phase changes.
                seg_cnt  <= (state_nxt != state) ? '0 : seg_cnt_inc;
                if ((state == S_WAIT) && trig_edge) begin
                    trig_addr <= wr_ptr;
                    evt_cnt   <= evt_cnt + 16'd1;
                end
            end else begin
                buf_we <= 1'b0;
                if (idle_arm) begin
                    wr_ptr  <= '0;
                    seg_cnt <= '0;
                    pre_q   <= pre_len;
                    post_q  <= post_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_capture_ctrl.sv
// Bench for pulse_capture_ctrl: directed scenarios plus random traffic,
// checked every cycle against a window-budget model for AW=10 and AW=4 instances.
module tb_pulse_capture_ctrl;

    localparam int DW = 14;

    logic          adc_clk = 1'b0;
    logic          adc_rstn = 1'b0;
    logic [DW-1:0] adc_dat_a;
    logic          trig_in;
    logic          arm;
    logic          abort;
    logic [9:0]    pre_len;
    logic [9:0]    post_len;

    logic          buf_we;
    logic [9:0]    buf_addr;
    logic [DW-1:0] buf_dat;
    logic [9:0]    trig_addr;
    logic          busy;
    logic          done;
    logic [15:0]   evt_cnt;

    logic          s_buf_we;
    logic [3:0]    s_buf_addr;
    logic [DW-1:0] s_buf_dat;
    logic [3:0]    s_trig_addr;
    logic          s_busy;
    logic          s_done;
    logic [15:0]   s_evt_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    bit ramp   = 1'b0;
    logic [DW-1:0] mem10 [1024];
    logic [10+DW-1:0] exp_q [$];

    // clock / reset block
    always #5 adc_clk = ~adc_clk;

    pulse_capture_ctrl #(.AW(10), .DW(DW)) dut (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat_a(adc_dat_a),
        .trig_in(trig_in), .arm(arm), .abort(abort),
        .pre_len(pre_len), .post_len(post_len),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_dat(buf_dat),
        .trig_addr(trig_addr), .busy(busy), .done(done), .evt_cnt(evt_cnt)
    );

    pulse_capture_ctrl #(.AW(4), .DW(DW)) dut4 (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat_a(adc_dat_a),
        .trig_in(trig_in), .arm(arm), .abort(abort),
        .pre_len(pre_len[3:0]), .post_len(post_len[3:0]),
        .buf_we(s_buf_we), .buf_addr(s_buf_addr), .buf_dat(s_buf_dat),
        .trig_addr(s_trig_addr), .busy(s_busy), .done(s_done), .evt_cnt(s_evt_cnt)
    );

    // Behavioural model: a capture is a budget of pre writes, an open-ended
    // trigger search, then a budget of post writes, on a ring of 'size' entries.
    typedef struct {
        int pre_left;
        bit searching;
        int post_left;
        int post_len;
        bit done;
        int ptr;
        bit trig_prev;
        bit we;
        int addr;
        int dat;
        int trig_addr;
        int evt;
        bit busy;
    } mdl_t;

    mdl_t m10;
    mdl_t m4;

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int size, bit arm_i, bit abort_i,
                                      bit trig_i, int adc, int pre_i, int post_i);
        bit rise;
        rise = trig_i && !m.trig_prev;
        m.trig_prev = trig_i;
        pre_i  = pre_i % size;
        post_i = post_i % size;
        if (abort_i) begin
            m.we = 0;
            m.pre_left = 0;
            m.searching = 0;
            m.post_left = 0;
            m.done = 0;
        end else if (m.pre_left > 0 || m.searching || m.post_left > 0) begin
            m.we   = 1;
            m.addr = m.ptr;
            m.dat  = adc;
            m.ptr  = (m.ptr + 1) % size;
            if (m.pre_left > 0) begin
                m.pre_left--;
                if (m.pre_left == 0) m.searching = 1;
            end else if (m.searching) begin
                if (rise) begin
                    m.trig_addr = m.addr;
                    m.evt = (m.evt + 1) % 65536;
                    m.searching = 0;
                    m.post_left = m.post_len;
                    m.done = (m.post_len == 0);
                end
            end else begin
                m.post_left--;
                m.done = (m.post_left == 0);
            end
        end else begin
            m.we = 0;
            if (arm_i) begin
                m.ptr = 0;
                m.pre_left = (pre_i == 0) ? 1 : pre_i;
                m.post_len = post_i;
                m.done = 0;
            end
        end
        m.busy = (m.pre_left > 0 || m.searching || m.post_left > 0);
        return m;
    endfunction

    // Model advances on the same edges (and async reset) as the DUTs.
    always @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            m10 <= mdl_zero();
            m4  <= mdl_zero();
            exp_q.delete();
        end else begin
            m10 <= mdl_step(m10, 1024, arm, abort, trig_in, int'(adc_dat_a),
                            int'(pre_len), int'(post_len));
            m4  <= mdl_step(m4, 16, arm, abort, trig_in, int'(adc_dat_a),
                            int'(pre_len), int'(post_len));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process and scoreboard, away from the active edge.
    always @(negedge adc_clk) begin
        logic [10+DW-1:0] got;
        chk("buf_we",      buf_we,      m10.we);
        chk("buf_addr",    buf_addr,    m10.addr);
        chk("buf_dat",     buf_dat,     m10.dat);
        chk("trig_addr",   trig_addr,   m10.trig_addr);
        chk("busy",        busy,        m10.busy);
        chk("done",        done,        m10.done);
        chk("evt_cnt",     evt_cnt,     m10.evt);
        chk("s_buf_we",    s_buf_we,    m4.we);
        chk("s_buf_addr",  s_buf_addr,  m4.addr);
        chk("s_buf_dat",   s_buf_dat,   m4.dat);
        chk("s_trig_addr", s_trig_addr, m4.trig_addr);
        chk("s_busy",      s_busy,      m4.busy);
        chk("s_done",      s_done,      m4.done);
        chk("s_evt_cnt",   s_evt_cnt,   m4.evt);
        if (m10.we) exp_q.push_back((10+DW)'((m10.addr << DW) | m10.dat));
        if (buf_we === 1'b1) begin
            wr_cnt++;
            mem10[buf_addr] = buf_dat;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_write: got write %0h/%0h expected no write", buf_addr, buf_dat);
            end else begin
                got = exp_q.pop_front();
                chk("sb_write", {buf_addr, buf_dat}, got);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge adc_clk);
        #1;
        if (ramp) adc_dat_a = adc_dat_a + 1'b1;
        else      adc_dat_a = DW'($urandom);
    endtask

    task automatic sample();
        @(negedge adc_clk);
        #1;
    endtask

    task automatic pulse_arm(input int pre, input int post);
        pre_len  = 10'(pre);
        post_len = 10'(post);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        adc_dat_a = '0;
        trig_in   = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
        pre_len   = '0;
        post_len  = '0;
        repeat (3) @(posedge adc_clk);
        #1;
        chk("rst_buf_we", buf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_evt", evt_cnt, 0);
        chk("rst_trig_addr", trig_addr, 0);
        adc_rstn = 1'b1;
        tick();

        // pre=4, post=3, ramp data, trigger edge 10 cycles after arm
        ramp = 1'b1;
        adc_dat_a = '0;
        wr_cnt = 0;
        pulse_arm(4, 3);
        repeat (9) tick();
        trig_in = 1'b1;
        tick();
        repeat (3) tick();
        sample();
        chk("t2_done", done, 1);
        chk("t2_trig_addr", trig_addr, 9);
        chk("t2_evt", evt_cnt, 1);
        chk("t2_last_addr", buf_addr, 12);
        tick();
        sample();
        chk("t2_we_after", buf_we, 0);
        chk("t2_writes", wr_cnt, 13);
        chk("t2_trig_sample", mem10[9], 10);
        ramp = 1'b0;

        // trigger level already high at arm is not an edge
        pulse_arm(4, 2);
        repeat (15) tick();
        sample();
        chk("t3_no_trig_evt", evt_cnt, 1);
        chk("t3_still_busy", busy, 1);
        trig_in = 1'b0;
        tick();
        trig_in = 1'b1;
        tick();
        repeat (2) tick();
        sample();
        chk("t3_done", done, 1);
        chk("t3_evt", evt_cnt, 2);

        // pulses during PRE are ignored
        trig_in = 1'b0;
        pulse_arm(8, 1);
        for (int i = 0; i < 7; i++) begin
            trig_in = i[0];
            tick();
        end
        trig_in = 1'b0;
        tick();
        sample();
        chk("t4_pre_evt", evt_cnt, 2);
        repeat (3) tick();
        trig_in = 1'b1;
        tick();
        tick();
        sample();
        chk("t4_done", done, 1);
        chk("t4_evt", evt_cnt, 3);

        // long WAIT wraps the AW=4 pointer; post_len=0 ends on the trigger sample
        trig_in = 1'b0;
        pulse_arm(2, 0);
        repeat (41) tick();
        trig_in = 1'b1;
        tick();
        sample();
        chk("t5_s_done", s_done, 1);
        chk("t5_s_trig_addr", s_trig_addr, 9);
        chk("t5_trig_addr", trig_addr, 41);
        chk("t5_s_last_we", s_buf_we, 1);
        chk("t5_s_last_addr", s_buf_addr, 9);
        tick();
        sample();
        chk("t5_s_we_after", s_buf_we, 0);

        // abort together with arm during WAIT
        trig_in = 1'b0;
        pulse_arm(3, 3);
        repeat (6) tick();
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        wr_cnt = 0;
        sample();
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_we", buf_we, 0);
        repeat (3) tick();
        sample();
        chk("t6_no_writes", wr_cnt, 0);
        pulse_arm(3, 20);
        tick();
        sample();
        chk("t6_rearm_we", buf_we, 1);
        chk("t6_rearm_addr", buf_addr, 0);

        // reset asserted mid-POST
        repeat (2) tick();
        trig_in = 1'b1;
        tick();
        repeat (5) tick();
        #2;
        adc_rstn = 1'b0;
        #1;
        chk("t7_busy_pre", busy, 0);
        chk("t7_we", buf_we, 0);
        chk("t7_addr", buf_addr, 0);
        chk("t7_dat", buf_dat, 0);
        chk("t7_trig_addr", trig_addr, 0);
        chk("t7_done", done, 0);
        chk("t7_evt", evt_cnt, 0);
        trig_in = 1'b0;
        repeat (2) tick();
        adc_rstn = 1'b1;
        repeat (3) tick();
        sample();
        chk("t7_idle_we", buf_we, 0);
        chk("t7_idle_busy", busy, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            arm   = ($urandom_range(0, 99) < 5);
            abort = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 15) trig_in = ~trig_in;
            pre_len  = 10'($urandom_range(0, 20));
            post_len = 10'($urandom_range(0, 20));
            if ($urandom_range(0, 199) == 0) pre_len = 10'($urandom_range(0, 300));
            if ($urandom_range(0, 199) == 0) post_len = 10'($urandom_range(0, 300));
            tick();
        end
        arm = 1'b0;
        abort = 1'b0;
        repeat (2) tick();
        sample();
        chk("sb_drained", exp_q.size(), 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_capture_ctrl.md
Name: pulse_capture_ctrl

Overview:
Capture controller directly downstream of the single-pulse threshold trigger. It consumes the trigger's level output, finds its rising edge, and writes a pre-trigger/post-trigger window of ADC channel-A samples into a circular dual-port sample buffer. The block reports the buffer address of the trigger sample and counts captured events for the processor-side readout.

Parameters:
AW, 10, sample buffer address width (buffer depth 2^AW)
DW, 14, ADC sample width

Ports:
adc_clk  in  1  ADC sample clock, rising edge
adc_rstn  in  1  asynchronous active-low reset
adc_dat_a  in  DW  ADC channel A sample
trig_in  in  1  level output of threshold trigger stage
arm  in  1  one-cycle pulse, starts a capture
abort  in  1  one-cycle pulse, cancels a capture
pre_len  in  AW  pre-trigger sample count, latched at arm
post_len  in  AW  post-trigger sample count, latched at arm
buf_we  out  1  buffer write enable (registered)
buf_addr  out  AW  buffer write address (registered)
buf_dat  out  DW  buffer write data (registered)
trig_addr  out  AW  buffer address of the trigger sample
busy  out  1  high in PRE, WAIT, POST
done  out  1  high in DONE
evt_cnt  out  16  number of accepted triggers

Behaviour:
- Clock is adc_clk. Reset is adc_rstn, asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, wr_ptr 0, trig_d 0.
- Edge detect: trig_d <= trig_in every cycle in all states. edge = trig_in & ~trig_d at a clock edge.
  - A trig_in level that is already high at arm never triggers. A new low-to-high transition is required.
- FSM states: IDLE, PRE, WAIT, POST, DONE. busy and done are decoded registered state bits.
- Write rule: at every edge where the current state is PRE, WAIT or POST:
  - buf_we <= 1, buf_addr <= wr_ptr, buf_dat <= adc_dat_a.
  - wr_ptr <= wr_ptr+1, modulo 2^AW, wrapping silently.
  - In all other states buf_we <= 0. buf_addr and buf_dat hold their values.
- IDLE/DONE + arm:
  - Go to PRE next edge.
  - wr_ptr <= 0, latch pre_len and post_len, clear done.
  - arm is ignored in PRE, WAIT and POST.
- PRE:
  - Performs exactly max(pre_len,1) writes, then goes to WAIT.
  - Edges during PRE are ignored, and trig_d still updates.
- WAIT:
  - Writes continuously; the buffer acts as a ring.
  - On edge at clock k, the sample written at k is the trigger sample.
  - trig_addr <= its address (the current wr_ptr), evt_cnt <= evt_cnt+1 (16-bit wrap), state <= POST.
  - The upstream trigger has 1-cycle latency, so the threshold-crossing sample sits at trig_addr-1 (mod 2^AW). Software accounts for this.
- POST:
  - Performs exactly post_len further writes after the trigger sample, then goes to DONE.
  - If post_len = 0, go WAIT -> DONE directly on the trigger edge. The trigger sample is the last write.
- DONE: no writes. done stays 1 until arm, abort or reset.
- abort:
  - From any state, go to IDLE next edge, buf_we <= 0, done <= 0.
  - abort has priority over arm and edge in the same cycle.
  - trig_addr and evt_cnt are not cleared.
- Window overflow: if pre_len+post_len+1 > 2^AW, writes wrap and overwrite the oldest pre-trigger data. This is defined behaviour with no clamp.
- Reset mid-capture: immediate return to reset values. A partial capture is lost.
- Total latency: adc_dat_a at edge k appears on buf_dat/buf_addr with buf_we=1 after edge k, so it is written at edge k+1.

Test Plan:
- Reset with adc_rstn low mid-POST -> all outputs 0 immediately. After release, state is IDLE and buf_we stays 0.
- arm with pre_len=4, post_len=3, ramp adc_dat_a (value = cycle index), trig_in rises 10 cycles after arm:
  - required: 4 PRE writes, then the WAIT writes up to and including the trigger sample, then exactly 3 more writes;
  - required: trig_addr = address holding the sample at the edge cycle, done=1, evt_cnt=1, buf_we=0 afterwards.
- trig_in high before arm and held high -> no trigger. Drop it, then raise it in WAIT -> trigger on that rise only.
- trig_in pulses during PRE (pre_len=8) -> ignored. First rise in WAIT is accepted. Check evt_cnt increments by 1.
- AW=4, pre_len=2, post_len=0, WAIT lasts 40 cycles -> wr_ptr wraps. Trigger sample is the last write, addresses are modulo 16, and DONE follows the trigger edge.
- abort and arm in the same cycle during WAIT -> IDLE, no further writes, done=0. A later arm restarts from address 0.
